fir_decimator: RTL and testbench



---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_out_reg.sv | 46 ++++
 rtl/fir_decimator.sv | 75 +++++++
 tb/tb_fir_decimator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR back-end stages.
package fir_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_LOG2 = 3;
  localparam int unsigned ACC_W    = DATA_W + MAX_LOG2;

  typedef enum logic [1:0] {
    DECIM_1 = 2'd0,
    DECIM_2 = 2'd1,
    DECIM_4 = 2'd2,
    DECIM_8 = 2'd3
  } decim_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Sample index of the final sample in a block of 2**k samples.
  function automatic logic [MAX_LOG2-1:0] last_cnt(input decim_e k);
    return MAX_LOG2'((32'd1 << 32'(k)) - 32'd1);
  endfunction

endpackage

// File: rtl/fir_out_reg.sv
// Single-entry valid/ready output register; accepts a load whenever empty or draining.
module fir_out_reg
  import fir_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         load_ready_c,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready
);

  out_state_e state_q;
  out_state_e state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= OUT_EMPTY;
    else       state_q <= state_d;
  end

  // A load in the same cycle as a drain keeps the register full with new data.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: if (load) state_d = OUT_FULL;
      OUT_FULL: begin
        if (load)          state_d = OUT_FULL;
        else if (m_tready) state_d = OUT_EMPTY;
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)     m_tdata <= '0;
    else if (load) m_tdata <= load_data;
  end

  assign m_tvalid     = (state_q == OUT_FULL);
  assign load_ready_c = (state_q == OUT_EMPTY) | m_tready;

endmodule

// File: rtl/fir_decimator.sv
// Block-averaging decimator: sums 2**k samples and emits the truncated mean.
module fir_decimator
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        decim_sel,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [7:0]        block_cnt
);

  logic [ACC_W-1:0]    acc;
  logic [MAX_LOG2-1:0] cnt;
  decim_e              k_lat;

  decim_e              k_eff_c;
  logic                first_c;
  logic                is_last_c;
  logic                in_xfer_c;
  logic                last_xfer_c;
  logic                load_ready_c;
  logic [ACC_W-1:0]    acc_base_c;
  logic [ACC_W-1:0]    sum_c;
  logic [DATA_W-1:0]   avg_c;

  // The factor is sampled at the first sample of each block.
  assign first_c     = (cnt == '0);
  assign k_eff_c     = first_c ? decim_e'(decim_sel) : k_lat;
  assign is_last_c   = (cnt == last_cnt(k_eff_c));
  assign acc_base_c  = first_c ? '0 : acc;
  assign sum_c       = acc_base_c + ACC_W'(s_axis_tdata);
  assign avg_c       = DATA_W'(sum_c >> k_eff_c);

  // Non-final samples are always accepted; the final one waits for output space.
  assign s_axis_tready = !is_last_c | load_ready_c;
  assign in_xfer_c     = s_axis_tvalid & s_axis_tready;
  assign last_xfer_c   = in_xfer_c & is_last_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      k_lat     <= DECIM_1;
      block_cnt <= '0;
    end else if (in_xfer_c) begin
      acc <= sum_c;
      if (first_c) k_lat <= decim_e'(decim_sel);
      if (is_last_c) begin
        cnt       <= '0;
        block_cnt <= block_cnt + 8'd1;
      end else begin
        cnt <= cnt + MAX_LOG2'(1);
      end
    end
  end

  fir_out_reg #(
    .W (DATA_W)
  ) u_out_reg (
    .clk          (clk),
    .reset        (reset),
    .load         (last_xfer_c),
    .load_data    (avg_c),
    .load_ready_c (load_ready_c),
    .m_tdata      (m_axis_tdata),
    .m_tvalid     (m_axis_tvalid),
    .m_tready     (m_axis_tready)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// Directed self-checking bench for fir_decimator.
module tb_fir_decimator;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] decim_sel;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] block_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  fir_decimator dut (
    .clk           (clk),
    .reset         (reset),
    .decim_sel     (decim_sel),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .block_cnt     (block_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    decim_sel     = 2'd0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    tick();
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_bcnt", 32'(block_cnt), 32'd0);
    reset = 1'b0;

    // Factor 1, streaming.
    drive(1'b1, 8'h10);
    chk("f1_rdy0", 32'(s_axis_tready), 32'd1);
    tick();
    chk("f1_v0", 32'(m_axis_tvalid), 32'd1);
    chk("f1_d0", 32'(m_axis_tdata), 32'h10);
    drive(1'b1, 8'h20);
    chk("f1_rdy1", 32'(s_axis_tready), 32'd1);
    tick();
    chk("f1_d1", 32'(m_axis_tdata), 32'h20);
    drive(1'b1, 8'hFF);
    chk("f1_rdy2", 32'(s_axis_tready), 32'd1);
    tick();
    chk("f1_d2", 32'(m_axis_tdata), 32'hFF);
    chk("f1_v2", 32'(m_axis_tvalid), 32'd1);
    chk("f1_bcnt", 32'(block_cnt), 32'd3);
    drive(1'b0, 8'h00);
    tick();
    chk("f1_drain", 32'(m_axis_tvalid), 32'd0);

    // Factor 4: 10+20+30+41 = 101, 101>>2 = 25.
    decim_sel = 2'd2;
    drive(1'b1, 8'd10);  tick(); chk("f4_nv1", 32'(m_axis_tvalid), 32'd0);
    drive(1'b1, 8'd20);  tick(); chk("f4_nv2", 32'(m_axis_tvalid), 32'd0);
    drive(1'b1, 8'd30);  tick(); chk("f4_nv3", 32'(m_axis_tvalid), 32'd0);
    drive(1'b1, 8'd41);  tick();
    chk("f4_v", 32'(m_axis_tvalid), 32'd1);
    chk("f4_d", 32'(m_axis_tdata), 32'd25);
    drive(1'b0, 8'd0);   tick();
    chk("f4_drain", 32'(m_axis_tvalid), 32'd0);
    chk("f4_bcnt", 32'(block_cnt), 32'd4);

    // Factor 8 at full scale: 8*255 = 2040, 2040>>3 = 255.
    decim_sel = 2'd3;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'hFF);
      tick();
    end
    chk("f8_nv7", 32'(m_axis_tvalid), 32'd0);
    drive(1'b1, 8'hFF); tick();
    chk("f8_v", 32'(m_axis_tvalid), 32'd1);
    chk("f8_d", 32'(m_axis_tdata), 32'hFF);
    drive(1'b0, 8'd0);  tick();
    chk("f8_bcnt", 32'(block_cnt), 32'd5);

    // Factor 2 with output stalled.
    decim_sel     = 2'd1;
    m_axis_tready = 1'b0;
    drive(1'b1, 8'd4);  tick();
    drive(1'b1, 8'd6);  tick();
    chk("st_v5", 32'(m_axis_tvalid), 32'd1);
    chk("st_d5", 32'(m_axis_tdata), 32'd5);
    drive(1'b1, 8'd8);
    chk("st_rdy8", 32'(s_axis_tready), 32'd1);
    tick();
    chk("st_hold_d", 32'(m_axis_tdata), 32'd5);
    chk("st_hold_v", 32'(m_axis_tvalid), 32'd1);
    drive(1'b1, 8'd10);
    chk("st_rdy10_lo", 32'(s_axis_tready), 32'd0);
    tick();
    chk("st_hold2_d", 32'(m_axis_tdata), 32'd5);
    chk("st_rdy10_lo2", 32'(s_axis_tready), 32'd0);
    m_axis_tready = 1'b1;
    #1;
    chk("st_rdy10_hi", 32'(s_axis_tready), 32'd1);
    tick();
    chk("st_v9", 32'(m_axis_tvalid), 32'd1);
    chk("st_d9", 32'(m_axis_tdata), 32'd9);
    drive(1'b0, 8'd0);  tick();
    chk("st_drain", 32'(m_axis_tvalid), 32'd0);
    chk("st_bcnt", 32'(block_cnt), 32'd7);

    // Mid-block factor change is ignored: (2+4)>>1 = 3.
    decim_sel = 2'd1;
    drive(1'b1, 8'd2);  tick();
    decim_sel = 2'd3;
    drive(1'b1, 8'd4);  tick();
    chk("mc_v", 32'(m_axis_tvalid), 32'd1);
    chk("mc_d", 32'(m_axis_tdata), 32'd3);
    // Next block uses factor 8: 1..8 sums to 36, 36>>3 = 4.
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 8'(i));
      tick();
      chk($sformatf("mc_nv%0d", i), 32'(m_axis_tvalid), 32'd0);
    end
    drive(1'b1, 8'd8);  tick();
    chk("mc8_v", 32'(m_axis_tvalid), 32'd1);
    chk("mc8_d", 32'(m_axis_tdata), 32'd4);
    chk("mc_bcnt", 32'(block_cnt), 32'd9);
    drive(1'b0, 8'd0);  tick();

    // Reset mid-block discards the partial sum.
    decim_sel = 2'd2;
    drive(1'b1, 8'd1);  tick();
    drive(1'b1, 8'd2);  tick();
    drive(1'b0, 8'd0);
    reset = 1'b1;
    tick();
    chk("mr_v", 32'(m_axis_tvalid), 32'd0);
    chk("mr_d", 32'(m_axis_tdata), 32'd0);
    chk("mr_bcnt", 32'(block_cnt), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'd4);
      tick();
    end
    chk("mr_nv", 32'(m_axis_tvalid), 32'd0);
    drive(1'b1, 8'd4);  tick();
    chk("mr_v4", 32'(m_axis_tvalid), 32'd1);
    chk("mr_d4", 32'(m_axis_tdata), 32'd4);
    chk("mr_bcnt1", 32'(block_cnt), 32'd1);
    drive(1'b0, 8'd0);  tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
